// File: rtl/seq_player.sv
// Multi-channel step sequencer: tempo divider, pattern select and pattern-RAM playback.
// Latency: tick in cycle T -> mem_rd in T+1 -> step_data/step_valid in T+3.
// Backpressure: none; the external RAM must return data the cycle after mem_rd.
//
// Ports:
//   CLK_50, reset (sync, active-low)      clock and reset
//   run, mode, seq_len                    play control, play mode, last step index
//   freq_up/freq_dn, seq_up/seq_dn        one-cycle pulses from the debouncers
//   mem_addr, mem_rd, mem_data            synchronous pattern RAM read port
//   step_data, step_valid, gate, tick     playback outputs
//   step, seq_num, freq_num, done         status outputs
module seq_player #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 10,
    parameter int STEP_W   = 7,
    parameter int SEQ_W    = 3,
    parameter int FREQ_W   = 3,
    parameter int FREQ_DEF = 3,
    parameter int BASE_DIV = 50000
) (
    input  logic                     CLK_50,
    input  logic                     reset,
    input  logic                     run,
    input  logic [1:0]               mode,
    input  logic                     freq_up,
    input  logic                     freq_dn,
    input  logic                     seq_up,
    input  logic                     seq_dn,
    input  logic [STEP_W-1:0]        seq_len,
    output logic [SEQ_W+STEP_W-1:0]  mem_addr,
    output logic                     mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [DATA_W-1:0]        step_data,
    output logic                     step_valid,
    output logic [CHANNELS-1:0]      gate,
    output logic                     tick,
    output logic [STEP_W-1:0]        step,
    output logic [SEQ_W-1:0]         seq_num,
    output logic [FREQ_W-1:0]        freq_num,
    output logic                     done
);

    localparam int FREQ_SPAN = 2 ** FREQ_W;
    localparam int CNT_W     = $clog2(BASE_DIV * FREQ_SPAN + 1);
    localparam logic [FREQ_W-1:0] FREQ_MAX = {FREQ_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           div_cnt_q, div_cnt_d;
    logic [STEP_W-1:0]          step_q, step_d;
    logic                       dir_dn_q, dir_dn_d;   // 1 = ping-pong moving down
    logic [SEQ_W-1:0]           seq_num_q, seq_num_d;
    logic [FREQ_W-1:0]          freq_num_q, freq_num_d;
    logic [DATA_W-1:0]          step_data_q, step_data_d;
    logic                       step_valid_q, step_valid_d;
    logic                       mem_rd_q, mem_rd_d;
    logic [SEQ_W+STEP_W-1:0]    mem_addr_q, mem_addr_d;
    logic                       done_q, done_d;

    logic [CNT_W-1:0]           period;
    logic                       tick_w;
    logic [STEP_W-1:0]          nxt_step;
    logic                       nxt_dir_dn;
    logic                       nxt_end;              // one-shot reached its last step

    always_comb begin
        // Recomputed from the live tempo index; the >= compare below lets a
        // tempo change that shortens the period fire a tick right away.
        period = CNT_W'(BASE_DIV) * (CNT_W'(FREQ_SPAN) - CNT_W'(freq_num_q));
        tick_w = (state_q == S_PLAY) && (div_cnt_q >= period - CNT_W'(1));

        // Next-step selection, only consumed on a tick in PLAY.
        nxt_step   = step_q + STEP_W'(1);
        nxt_dir_dn = 1'b0;
        nxt_end    = 1'b0;
        case (mode)
            2'b01: begin
                nxt_end = (step_q >= seq_len);
            end
            2'b10: begin
                nxt_dir_dn = dir_dn_q;
                if (!dir_dn_q) begin
                    if (step_q >= seq_len) begin
                        // min(step, seq_len) is seq_len on this branch.
                        nxt_dir_dn = 1'b1;
                        nxt_step   = (seq_len == '0) ? '0 : seq_len - STEP_W'(1);
                    end
                end else begin
                    if (step_q == '0) begin
                        nxt_dir_dn = 1'b0;
                        nxt_step   = (seq_len == '0) ? '0 : STEP_W'(1);
                    end else begin
                        nxt_step   = step_q - STEP_W'(1);
                    end
                end
            end
            default: begin
                if (step_q >= seq_len) begin
                    nxt_step = '0;
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = '0;
        step_d       = step_q;
        dir_dn_d     = dir_dn_q;
        seq_num_d    = seq_num_q;
        freq_num_d   = freq_num_q;
        step_data_d  = step_data_q;
        step_valid_d = 1'b0;
        mem_rd_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        done_d       = done_q;

        // Tempo and pattern selection are live in every state.
        if (freq_up && !freq_dn && freq_num_q != FREQ_MAX) begin
            freq_num_d = freq_num_q + FREQ_W'(1);
        end else if (freq_dn && !freq_up && freq_num_q != '0) begin
            freq_num_d = freq_num_q - FREQ_W'(1);
        end

        if (seq_up && !seq_dn) begin
            seq_num_d = seq_num_q + SEQ_W'(1);
        end else if (seq_dn && !seq_up) begin
            seq_num_d = seq_num_q - SEQ_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d  = S_FETCH;
                    step_d   = '0;
                    dir_dn_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (!run) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                // Stopping here drops the returning RAM word unlatched.
                if (!run) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    state_d      = S_PLAY;
                    step_data_d  = mem_data;
                    step_valid_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (!run) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (tick_w) begin
                    if (nxt_end) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_FETCH;
                        step_d   = nxt_step;
                        dir_dn_d = nxt_dir_dn;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!run) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read strobe and address are registered so they line up with FETCH.
        if (state_d == S_FETCH) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {seq_num_d, step_d};
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            step_q       <= '0;
            dir_dn_q     <= 1'b0;
            seq_num_q    <= '0;
            freq_num_q   <= FREQ_W'(FREQ_DEF);
            step_data_q  <= '0;
            step_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            step_q       <= step_d;
            dir_dn_q     <= dir_dn_d;
            seq_num_q    <= seq_num_d;
            freq_num_q   <= freq_num_d;
            step_data_q  <= step_data_d;
            step_valid_q <= step_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            done_q       <= done_d;
        end
    end

    // Gate and tick decode straight from registered state: the 50% gate
    // window and the tick must sit in the same cycle as the counter value.
    always_comb begin
        gate = '0;
        if (state_q == S_PLAY && div_cnt_q < (period >> 1)) begin
            gate = step_data_q[CHANNELS-1:0];
        end
    end

    assign tick       = tick_w;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign step_data  = step_data_q;
    assign step_valid = step_valid_q;
    assign step       = step_q;
    assign seq_num    = seq_num_q;
    assign freq_num   = freq_num_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with BASE_DIV=8, FREQ_W=2, FREQ_DEF=1 (period 24).
// Pattern RAM model returns its own address one cycle after mem_rd.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_player;

    logic       clk;
    logic       reset;
    logic       run;
    logic [1:0] mode;
    logic       freq_up, freq_dn, seq_up, seq_dn;
    logic [6:0] seq_len;
    logic [9:0] mem_addr;
    logic       mem_rd;
    logic [9:0] mem_data;
    logic [9:0] step_data;
    logic       step_valid;
    logic [3:0] gate;
    logic       tick;
    logic [6:0] step;
    logic [2:0] seq_num;
    logic [1:0] freq_num;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_player #(
        .CHANNELS(4), .DATA_W(10), .STEP_W(7), .SEQ_W(3),
        .FREQ_W(2), .FREQ_DEF(1), .BASE_DIV(8)
    ) dut (
        .CLK_50    (clk),
        .reset     (reset),
        .run       (run),
        .mode      (mode),
        .freq_up   (freq_up),
        .freq_dn   (freq_dn),
        .seq_up    (seq_up),
        .seq_dn    (seq_dn),
        .seq_len   (seq_len),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .step_data (step_data),
        .step_valid(step_valid),
        .gate      (gate),
        .tick      (tick),
        .step      (step),
        .seq_num   (seq_num),
        .freq_num  (freq_num),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word(addr) = addr, registered read
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic fu, input logic fd, input logic su, input logic sd);
        freq_up = fu; freq_dn = fd; seq_up = su; seq_dn = sd;
        cyc();
        freq_up = 0; freq_dn = 0; seq_up = 0; seq_dn = 0;
    endtask

    // From IDLE: raise run and follow FETCH -> LATCH -> first PLAY cycle.
    task automatic start_run(input logic [1:0] m, input logic [6:0] len, input logic [9:0] addr);
        mode = m; seq_len = len; run = 1;
        cyc();
        chk("start_mem_rd", mem_rd, 1);
        chk("start_mem_addr", mem_addr, addr);
        cyc();
        chk("latch_mem_rd", mem_rd, 0);
        cyc();
        chk("start_step_valid", step_valid, 1);
        chk("start_step_data", step_data, addr);
        chk("start_step", step, 0);
    endtask

    // From the first PLAY cycle: count PLAY cycles up to and including the tick.
    task automatic wait_tick(input int exp_len, input int exp_gate);
        int n;
        int g;
        bit fin;
        n = 0; g = 0; fin = 0;
        while (!fin) begin
            n++;
            if (gate != 0) g++;
            if (tick === 1'b1 || n >= 300) fin = 1;
            else cyc();
        end
        chk("play_len", n, exp_len);
        chk("gate_cycles", g, exp_gate);
    endtask

    task automatic play_one(input logic [6:0] exp_step, input logic [9:0] exp_addr,
                            input int exp_len, input int exp_gate);
        wait_tick(exp_len, exp_gate);
        cyc();
        chk("fetch_mem_rd", mem_rd, 1);
        chk("fetch_mem_addr", mem_addr, exp_addr);
        cyc();
        cyc();
        chk("step_valid", step_valid, 1);
        chk("step", step, exp_step);
        chk("step_data", step_data, exp_addr);
    endtask

    task automatic stop_run();
        run = 0;
        cyc();
        chk("stop_step", step, 0);
        chk("stop_gate", gate, 0);
        chk("stop_mem_rd", mem_rd, 0);
    endtask

    initial begin
        reset = 0; run = 0; mode = 0; seq_len = 0;
        freq_up = 0; freq_dn = 0; seq_up = 0; seq_dn = 0;
        mem_data = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_step_data", step_data, 0);
        chk("rst_gate", gate, 0);
        chk("rst_tick", tick, 0);
        chk("rst_step", step, 0);
        chk("rst_seq_num", seq_num, 0);
        chk("rst_freq_num", freq_num, 1);
        chk("rst_done", done, 0);
        reset = 1;

        // Loop, seq_len=3: 0,1,2,3,0,1
        start_run(2'b00, 7'd3, 10'd0);
        play_one(7'd1, 10'd1, 24, 0);
        play_one(7'd2, 10'd2, 24, 12);
        play_one(7'd3, 10'd3, 24, 12);
        play_one(7'd0, 10'd0, 24, 12);
        play_one(7'd1, 10'd1, 24, 0);
        stop_run();

        // Ping-pong, seq_len=3: 0,1,2,3,2,1,0,1
        start_run(2'b10, 7'd3, 10'd0);
        play_one(7'd1, 10'd1, 24, 0);
        play_one(7'd2, 10'd2, 24, 12);
        play_one(7'd3, 10'd3, 24, 12);
        play_one(7'd2, 10'd2, 24, 12);
        play_one(7'd1, 10'd1, 24, 12);
        play_one(7'd0, 10'd0, 24, 12);
        play_one(7'd1, 10'd1, 24, 0);
        stop_run();

        // Ping-pong, seq_len=0: step stays 0
        start_run(2'b10, 7'd0, 10'd0);
        play_one(7'd0, 10'd0, 24, 0);
        play_one(7'd0, 10'd0, 24, 0);
        stop_run();

        // One-shot, seq_len=2: 0,1,2 then DONE
        start_run(2'b01, 7'd2, 10'd0);
        play_one(7'd1, 10'd1, 24, 0);
        play_one(7'd2, 10'd2, 24, 12);
        wait_tick(24, 12);
        cyc();
        chk("os_done", done, 1);
        chk("os_gate", gate, 0);
        chk("os_step", step, 2);
        chk("os_mem_rd", mem_rd, 0);
        cyc();
        chk("os_done_hold", done, 1);
        run = 0;
        cyc();
        chk("os_done_clr", done, 0);

        // Tempo saturation and simultaneous pulses
        pulse(1, 0, 0, 0);
        chk("freq_up1", freq_num, 2);
        pulse(1, 0, 0, 0);
        chk("freq_up2", freq_num, 3);
        pulse(1, 0, 0, 0);
        chk("freq_sat", freq_num, 3);
        pulse(1, 1, 0, 0);
        chk("freq_both", freq_num, 3);

        // Pattern wrap and simultaneous pulses
        pulse(0, 0, 0, 1);
        chk("seq_wrap", seq_num, 7);
        pulse(0, 0, 1, 1);
        chk("seq_both", seq_num, 7);

        // Period 8, pattern 7: addresses 896.. ; gate 4 cycles for word 897
        start_run(2'b00, 7'd3, 10'd896);
        play_one(7'd1, 10'd897, 8, 0);
        play_one(7'd2, 10'd898, 8, 4);
        stop_run();

        // run=0 during LATCH: no step_valid, step_data untouched
        run = 1;
        cyc();
        chk("ab_mem_rd", mem_rd, 1);
        chk("ab_mem_addr", mem_addr, 896);
        cyc();
        run = 0;
        cyc();
        chk("ab_step_valid", step_valid, 0);
        chk("ab_step", step, 0);
        chk("ab_step_data", step_data, 898);
        chk("ab_mem_rd_idle", mem_rd, 0);
        cyc();
        chk("ab_step_valid2", step_valid, 0);

        // Reset mid-PLAY
        start_run(2'b00, 7'd3, 10'd896);
        play_one(7'd1, 10'd897, 8, 0);
        cyc();
        chk("pre_rst_gate", gate, 1);
        reset = 0;
        cyc();
        chk("mrst_gate", gate, 0);
        chk("mrst_step", step, 0);
        chk("mrst_step_data", step_data, 0);
        chk("mrst_step_valid", step_valid, 0);
        chk("mrst_mem_rd", mem_rd, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_tick", tick, 0);
        chk("mrst_seq_num", seq_num, 0);
        chk("mrst_freq_num", freq_num, 1);
        chk("mrst_done", done, 0);
        reset = 1;
        run = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
